dut_arst_sampler: RTL and testbench

//   Samples the single-bit async input A into the CLK domain through a

---
 rtl/dut_arst_pkg.sv | 17 +
 rtl/dut_arst_sampler_sync_chain.sv | 34 +++
 rtl/dut_arst_sampler.sv | 70 +++++++
 tb/tb_dut_arst_sampler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dut_arst_pkg.sv
// Shared definitions for the asynchronous-input sampler.
//   SYNC_STAGES_DEF / CNT_W_DEF : default synchronizer depth and counter width
//   SYNC_STAGES_MIN / _MAX      : legal synchronizer depth range
//   sync_depth_ok()             : elaboration-time range check helper
package dut_arst_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic bit sync_depth_ok(input int depth);
    return (depth >= SYNC_STAGES_MIN) && (depth <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/dut_arst_sampler_sync_chain.sv
// Multi-flop synchronizer with asynchronous active-high clear.
// Ports:
//   clk        in  1  sampling clock, rising edge
//   clr        in  1  asynchronous clear, active-high
//   a          in  1  asynchronous level to be synchronized
//   tap_first  out 1  first-stage sample (may be metastable, observe only)
//   tap_last   out 1  last-stage, synchronized level
module arst_sync_chain
  import dut_arst_pkg::*;
#(
  parameter int DEPTH = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic a,
  output logic tap_first,
  output logic tap_last
);

  logic [DEPTH-1:0] stage;

  // Shift chain: stage[0] captures a, each later stage copies its predecessor
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stage <= '0;
    end else begin
      stage <= {stage[DEPTH-2:0], a};
    end
  end

  assign tap_first = stage[0];
  assign tap_last  = stage[DEPTH-1];

endmodule

// File: rtl/dut_arst_sampler.sv
// Brings the asynchronous level A into the CLK domain, flags rising and
// falling edges of the synchronized level and counts them.
// Ports:
//   CLK       in  1      clock, all flops rising-edge
//   RST       in  1      asynchronous active-high reset, clears every flop
//   A         in  1      asynchronous level input
//   Q         out 1      raw first-stage sample of A
//   Q_SYNC    out 1      synchronized level of A (SYNC_STAGES edges latency)
//   RISE      out 1      registered one-cycle pulse, Q_SYNC went 0->1
//   FALL      out 1      registered one-cycle pulse, Q_SYNC went 1->0
//   EDGE_CNT  out CNT_W  RISE+FALL events since reset, wraps modulo 2**CNT_W
module dut_arst_sampler
  import dut_arst_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A,
  output logic             Q,
  output logic             Q_SYNC,
  output logic             RISE,
  output logic             FALL,
  output logic [CNT_W-1:0] EDGE_CNT
);

  localparam bit DEPTH_OK = sync_depth_ok(SYNC_STAGES);

  if (!DEPTH_OK) begin : g_bad_depth
    $error("dut_arst_sampler: SYNC_STAGES must be in 2..4");
  end

  logic prev_p1;
  logic chg;

  // Synchronizer stages
  arst_sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk       (CLK),
    .clr       (RST),
    .a         (A),
    .tap_first (Q),
    .tap_last  (Q_SYNC)
  );

  // Any difference between the synchronized level and its delayed copy is an edge
  assign chg = Q_SYNC ^ prev_p1;

  // Edge-detect and counter stage: the pulse and the count update land on the
  // same clock edge, so EDGE_CNT already includes the pulse being shown.
  // prev_p1 resets to 0, so a level held high through reset shows up as a rise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_p1  <= 1'b0;
      RISE     <= 1'b0;
      FALL     <= 1'b0;
      EDGE_CNT <= '0;
    end else begin
      prev_p1 <= Q_SYNC;
      RISE    <= Q_SYNC & ~prev_p1;
      FALL    <= ~Q_SYNC & prev_p1;
      if (chg) begin
        EDGE_CNT <= EDGE_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dut_arst_sampler.sv
module tb_dut_arst_sampler;

  localparam int S     = 2;
  localparam int CNT_W = 8;

  logic             CLK;
  logic             RST;
  logic             A;
  logic             Q;
  logic             Q_SYNC;
  logic             RISE;
  logic             FALL;
  logic [CNT_W-1:0] EDGE_CNT;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  dut_arst_sampler #(
    .SYNC_STAGES (S),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .A        (A),
    .Q        (Q),
    .Q_SYNC   (Q_SYNC),
    .RISE     (RISE),
    .FALL     (FALL),
    .EDGE_CNT (EDGE_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: list of A values sampled on each edge since reset.
  // The synchronized level after m edges is the sample taken S-1 edges
  // earlier; RISE/FALL after n edges compare the level after n-1 and n-2
  // edges; every such difference is one counted event.
  logic samp[$];
  int   mcnt;

  function automatic logic lvl(input int m);
    if (m - S + 1 >= 1) return samp[m - S];
    return 1'b0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp.delete();
      mcnt = 0;
    end else begin
      samp.push_back(A);
      if (lvl(samp.size() - 1) !== lvl(samp.size() - 2)) mcnt++;
    end
  end

  // Compare process, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      int n;
      logic exp_q;
      n = samp.size();
      exp_q = (n >= 1) ? samp[n-1] : 1'b0;
      check("q",      32'(Q),        32'(exp_q));
      check("q_sync", 32'(Q_SYNC),   32'(lvl(n)));
      check("rise",   32'(RISE),     32'(lvl(n-1) & ~lvl(n-2)));
      check("fall",   32'(FALL),     32'(~lvl(n-1) & lvl(n-2)));
      check("cnt",    32'(EDGE_CNT), 32'(mcnt % (1 << CNT_W)));
      check("rise_fall_excl", 32'(RISE & FALL), 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_q"},      32'(Q),        32'd0);
    check({name, "_qs"},     32'(Q_SYNC),   32'd0);
    check({name, "_rise"},   32'(RISE),     32'd0);
    check({name, "_fall"},   32'(FALL),     32'd0);
    check({name, "_cnt"},    32'(EDGE_CNT), 32'd0);
  endtask

  initial begin
    logic [CNT_W-1:0] prev_cnt;
    logic             prev_rise;
    bit               wrapped;

    // 1: reset held with A toggling (A starts unknown)
    A   = 1'bx;
    RST = 1'b1;
    tick();
    chk_en = 1;
    for (int i = 0; i < 3; i++) begin
      A = (i % 2 == 0);
      tick();
      check_all_zero("rst_hold");
    end

    // 2: release with A=0, then a single 0->1
    A = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    A = 1'b1;
    tick();
    check("t2_q_e1", 32'(Q), 32'd1);
    check("t2_qs_e1", 32'(Q_SYNC), 32'd0);
    tick();
    check("t2_qs_e2", 32'(Q_SYNC), 32'd1);
    check("t2_rise_e2", 32'(RISE), 32'd0);
    tick();
    check("t2_rise_e3", 32'(RISE), 32'd1);
    check("t2_cnt_e3", 32'(EDGE_CNT), 32'd1);
    tick();
    check("t2_rise_e4", 32'(RISE), 32'd0);
    check("t2_cnt_e4", 32'(EDGE_CNT), 32'd1);

    // 3: 1->0
    A = 1'b0;
    tick();
    tick();
    check("t3_qs_e2", 32'(Q_SYNC), 32'd0);
    tick();
    check("t3_fall_e3", 32'(FALL), 32'd1);
    check("t3_rise_e3", 32'(RISE), 32'd0);
    check("t3_cnt_e3", 32'(EDGE_CNT), 32'd2);
    tick();
    check("t3_fall_e4", 32'(FALL), 32'd0);
    check("t3_cnt_e4", 32'(EDGE_CNT), 32'd2);

    // 4: asynchronous assert mid-cycle, A held high across release
    #1 RST = 1'b1;
    #1 check_all_zero("t4_async");
    A = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("t4_q_e1", 32'(Q), 32'd1);
    check("t4_rise_e1", 32'(RISE), 32'd0);
    tick();
    check("t4_qs_e2", 32'(Q_SYNC), 32'd1);
    check("t4_rise_e2", 32'(RISE), 32'd0);
    tick();
    check("t4_rise_e3", 32'(RISE), 32'd1);
    check("t4_cnt_e3", 32'(EDGE_CNT), 32'd1);
    tick();
    check("t4_cnt_e4", 32'(EDGE_CNT), 32'd1);

    // 5: toggle every cycle for 300 cycles, counter must wrap
    wrapped   = 0;
    prev_cnt  = EDGE_CNT;
    prev_rise = RISE;
    for (int i = 1; i <= 300; i++) begin
      A = ~A;
      tick();
      if (prev_cnt == 8'd255 && EDGE_CNT == 8'd0) wrapped = 1;
      if (i >= 5) begin
        check("t5_one_pulse", 32'(RISE ^ FALL), 32'd1);
        check("t5_alternate", 32'(RISE != prev_rise), 32'd1);
      end
      prev_cnt  = EDGE_CNT;
      prev_rise = RISE;
    end
    check("t5_wrapped", 32'(wrapped), 32'd1);

    // 6: half-period reset pulse mid-stream, then resume from 0
    #1 RST = 1'b1;
    A = 1'b1;
    #1 check_all_zero("t6_async");
    #4 RST = 1'b0;
    tick();
    check("t6_cnt_e1", 32'(EDGE_CNT), 32'd0);
    A = 1'b0;
    tick();
    check("t6_cnt_e2", 32'(EDGE_CNT), 32'd0);
    for (int i = 3; i <= 20; i++) begin
      A = ~A;
      tick();
    end
    check("t6_cnt_e20", 32'(EDGE_CNT), 32'd18);

    tick();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
